// File: rtl/trim_pkg.sv
// trim_pkg: shared constants and state encoding for the trim capture path
package trim_pkg;
   localparam int CLK50_HZ = 50_000_000;
   localparam int TRIM_W = 12;
   localparam int GAP_CYCLES_DEF = CLK50_HZ / 4 * 3;
   typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, CLOSE = 2'd2} state_t;
endpackage

// File: rtl/trim_capture_sync_edge.sv
// sync_edge: multi-flop synchroniser with a delayed copy and rise/fall pulses
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic CLK50,
   input  logic RST,
   input  logic d,
   output logic q,
   output logic q_d,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] sr;
   always_ff @(posedge CLK50 or posedge RST)
      if (RST) begin
         sr  <= '0;
         q_d <= 1'b0;
      end else begin
         sr  <= {sr[STAGES-2:0], d};
         q_d <= sr[STAGES-1];
      end
   assign q    = sr[STAGES-1];
   assign rise = q & ~q_d;
   assign fall = ~q & q_d;
endmodule

// File: rtl/trim_capture.sv
// trim_capture: deserialises the ENCLK/DIN trim stream into gap-delimited frames
module trim_capture
   import trim_pkg::*;
#(
   parameter int FRAME_BITS  = TRIM_W,
   parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  CLK50,
   input  logic                  RST,
   input  logic                  ENCLK,
   input  logic                  DIN,
   output logic [FRAME_BITS-1:0] TRIM_OUT,
   output logic                  TRIM_VALID,
   output logic                  FRAME_ERR,
   output logic                  OVERRUN,
   output logic [7:0]            FRAME_COUNT
);
   localparam int GAP_W = $clog2(GAP_CYCLES) + 1;
   state_t state, state_nx;
   logic enclk_s, enclk_lvl, enclk_rise, enclk_fall, din_s;
   logic din_unused_d, din_unused_rise, din_unused_fall;
   logic [FRAME_BITS-1:0] shift;
   logic [4:0] bit_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic gap_done, full;
   sync_edge #(.STAGES(SYNC_STAGES)) u_enclk (
      .CLK50(CLK50), .RST(RST), .d(ENCLK),
      .q(enclk_s), .q_d(enclk_lvl), .rise(enclk_rise), .fall(enclk_fall)
   );
   sync_edge #(.STAGES(SYNC_STAGES)) u_din (
      .CLK50(CLK50), .RST(RST), .d(DIN),
      .q(din_s), .q_d(din_unused_d), .rise(din_unused_rise), .fall(din_unused_fall)
   );
   // the older ENCLK sample is high in the fall cycle, so sampling also clears the gap
   assign gap_done = !enclk_lvl && gap_cnt == GAP_W'(GAP_CYCLES - 1);
   assign full     = bit_cnt >= 5'(FRAME_BITS);
   always_ff @(posedge CLK50 or posedge RST)
      if (RST) state <= IDLE;
      else     state <= state_nx;
   always_comb
      state_nx = state == IDLE ? (enclk_rise ? RECV : IDLE) :
                 state == RECV ? (gap_done ? CLOSE : RECV) : IDLE;
   always_comb
      TRIM_VALID = state == CLOSE && full;
   // outputs load on entry to CLOSE so TRIM_OUT is already new while TRIM_VALID is high
   always_ff @(posedge CLK50 or posedge RST)
      if (RST) begin
         shift       <= '0;
         bit_cnt     <= '0;
         gap_cnt     <= '0;
         TRIM_OUT    <= '0;
         FRAME_ERR   <= 1'b0;
         OVERRUN     <= 1'b0;
         FRAME_COUNT <= '0;
      end else if (state == IDLE) begin
         if (enclk_rise) begin
            shift   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
         end
      end else if (state == RECV) begin
         gap_cnt <= enclk_lvl ? '0 : gap_cnt + GAP_W'(1);
         if (enclk_fall) begin
            shift   <= {din_s, shift[FRAME_BITS-1:1]};
            bit_cnt <= bit_cnt + 5'(bit_cnt != 5'd31);
         end
         if (gap_done) begin
            TRIM_OUT    <= full ? shift : TRIM_OUT;
            FRAME_COUNT <= full ? FRAME_COUNT + 8'd1 : FRAME_COUNT;
            FRAME_ERR   <= !full;
            OVERRUN     <= bit_cnt > 5'(FRAME_BITS);
         end
      end
endmodule

// File: tb/tb_trim_capture.sv
// tb_trim_capture: randomized frames checked against a bit-list reference model
module tb_trim_capture;
   localparam int FB = 12;
   localparam int GAP = 20;
   localparam int SYNC = 2;
   logic clk50 = 1'b0, rst = 1'b1, enclk = 1'b0, din = 1'b0;
   logic [FB-1:0] trim_out;
   logic trim_valid, frame_err, overrun;
   logic [7:0] frame_count;
   int cyc = 0, vcount = 0, vcyc = 0, c_fall = 0;
   logic [FB-1:0] vword = '0;
   int n_chk = 0, n_fail = 0;
   logic [FB-1:0] exp_out;
   logic [7:0] exp_cnt;
   logic exp_err, exp_ovr;
   trim_capture #(.FRAME_BITS(FB), .GAP_CYCLES(GAP), .SYNC_STAGES(SYNC)) dut (
      .CLK50(clk50), .RST(rst), .ENCLK(enclk), .DIN(din),
      .TRIM_OUT(trim_out), .TRIM_VALID(trim_valid), .FRAME_ERR(frame_err),
      .OVERRUN(overrun), .FRAME_COUNT(frame_count)
   );
   always #10 clk50 = ~clk50;
   always @(posedge clk50) cyc <= cyc + 1;
   always @(negedge clk50)
      if (trim_valid) begin
         vcount <= vcount + 1;
         vword  <= trim_out;
         vcyc   <= cyc;
      end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) @(negedge clk50);
   endtask
   task automatic do_reset();
      enclk = 1'b0;
      din = 1'b0;
      rst = 1'b1;
      tick(3);
      chk("rst_trim_out", 32'(trim_out), 0);
      chk("rst_valid", 32'(trim_valid), 0);
      chk("rst_err", 32'(frame_err), 0);
      chk("rst_ovr", 32'(overrun), 0);
      chk("rst_count", 32'(frame_count), 0);
      rst = 1'b0;
      exp_out = '0;
      exp_cnt = '0;
      exp_err = 1'b0;
      exp_ovr = 1'b0;
      tick(3);
   endtask
   // n pulses, 5 cycles high / 5 low, except long_low cycles low after bit long_idx
   task automatic pulses(input logic [31:0] data, input int n, input int long_idx, input int long_low);
      for (int i = 0; i < n; i++) begin
         din = data[i];
         enclk = 1'b1;
         tick(5);
         enclk = 1'b0;
         c_fall = cyc;
         tick(i == long_idx ? long_low : 5);
      end
   endtask
   task automatic frame(input logic [31:0] data, input int n, input int long_idx, input int long_low);
      int v0;
      logic good;
      v0 = vcount;
      pulses(data, n, long_idx, long_low);
      tick(30);
      good = n >= FB;
      if (good) begin
         exp_out = FB'(data >> (n - FB));
         exp_cnt = exp_cnt + 8'd1;
      end
      exp_err = !good;
      exp_ovr = n > FB;
      chk("valid_pulses", 32'(vcount - v0), 32'(good));
      chk("trim_out", 32'(trim_out), 32'(exp_out));
      chk("frame_count", 32'(frame_count), 32'(exp_cnt));
      chk("frame_err", 32'(frame_err), 32'(exp_err));
      chk("overrun", 32'(overrun), 32'(exp_ovr));
      if (good) begin
         chk("valid_word", 32'(vword), 32'(exp_out));
         chk("latency", 32'(vcyc - c_fall), 32'(GAP + SYNC + 1));
      end
   endtask
   initial begin
      int v0;
      int n;
      do_reset();
      frame(32'hA5C, 12, -1, 5);
      frame(32'h007, 14, -1, 5);
      frame(32'h055, 7, -1, 5);
      frame($urandom, 12, -1, 5);
      pulses(32'h2A, 6, -1, 5);
      rst = 1'b1;
      tick(2);
      chk("midrst_trim_out", 32'(trim_out), 0);
      chk("midrst_count", 32'(frame_count), 0);
      rst = 1'b0;
      exp_out = '0;
      exp_cnt = '0;
      exp_err = 1'b0;
      exp_ovr = 1'b0;
      tick(3);
      frame(32'h3FF, 12, -1, 5);
      frame($urandom, 12, 5, GAP - 1);
      v0 = vcount;
      pulses($urandom, 6, 5, GAP);
      enclk = 1'b1;
      tick(5);
      chk("gap20_err", 32'(frame_err), 1);
      chk("gap20_valid", 32'(vcount - v0), 0);
      enclk = 1'b0;
      tick(30);
      do_reset();
      for (int k = 0; k < 20; k++) begin
         n = $urandom_range(4, 16);
         frame($urandom, n, $urandom_range(0, n - 1), $urandom_range(5, GAP - 1));
      end
      do_reset();
      v0 = vcount;
      for (int k = 0; k < 256; k++)
         frame($urandom, $urandom_range(12, 14), -1, 5);
      chk("wrap_count", 32'(frame_count), 0);
      chk("wrap_pulses", 32'(vcount - v0), 256);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule
